// File: rtl/flag_join16.sv
// Sticky per-lane completion flags with masking, one handshake per round, early-pulse buffering and a round counter.
// Optional per-round abort timer is enabled by defining FLAG_JOIN_TIMEOUT_EN.
module flag_join16 #(
  parameter int WIDTH   = 16,
  parameter int RND_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] flags_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [RND_W-1:0] round_o,
  output logic [WIDTH-1:0] pend_o,
  output logic             timeout_o
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_e;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("flag_join16: TIMEOUT must be in 2..65535");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [WIDTH-1:0] nxt;
  logic             full;

  // Masked lanes count as done, but masking never clears a stored flag.
  assign nxt  = flags_q | set_i;
  assign full = &(nxt | mask_i);

`ifdef FLAG_JOIN_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      flags_q   <= '0;
      pend_q    <= '0;
      round_q   <= '0;
`ifdef FLAG_JOIN_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      pend_q    <= pend_d;
      round_q   <= round_d;
`ifdef FLAG_JOIN_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (full) state_d = S_DONE;
      S_DONE:    if (done_ready_i) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Datapath next values.
  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    flags_d   = flags_q;
    pend_d    = pend_q;
    round_d   = round_q;
`ifdef FLAG_JOIN_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      S_COLLECT: begin
        flags_d = nxt;
`ifdef FLAG_JOIN_TIMEOUT_EN
        // Completion on the same edge as expiry wins over the abort.
        if (full) begin
          cnt_d = '0;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          flags_d   = '0;
          pend_d    = '0;
          cnt_d     = '0;
        end else if (flags_q != '0) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
        end
`endif
      end
      S_DONE: begin
        pend_d = pend_q | set_i;
        if (done_ready_i) begin
          // Same-edge pulses seed the next round instead of being dropped.
          flags_d = pend_q | set_i;
          pend_d  = '0;
          round_d = round_q + 1'b1;
`ifdef FLAG_JOIN_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    flags_o      = flags_q;
    pend_o       = pend_q;
    round_o      = round_q;
    done_valid_o = (state_q == S_DONE);
`ifdef FLAG_JOIN_TIMEOUT_EN
    timeout_o    = timeout_q;
`else
    timeout_o    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_flag_join16.sv
// Directed bench for flag_join16: reset, sequential join, masking, early buffering, round wrap and the abort timer.
// The timer section follows FLAG_JOIN_TIMEOUT_EN the same way the design does.
module tb_flag_join16;

  localparam int WIDTH = 16;
  localparam int RND_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] set_i;
  logic [WIDTH-1:0] mask_i;
  logic [WIDTH-1:0] flags_o;
  logic             done_valid_o;
  logic             done_ready_i;
  logic [RND_W-1:0] round_o;
  logic [WIDTH-1:0] pend_o;
  logic             timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  flag_join16 #(
    .WIDTH  (WIDTH),
    .RND_W  (RND_W),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_i       (set_i),
    .mask_i      (mask_i),
    .flags_o     (flags_o),
    .done_valid_o(done_valid_o),
    .done_ready_i(done_ready_i),
    .round_o     (round_o),
    .pend_o      (pend_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_flags;
    logic [RND_W-1:0] exp_round;

    rst          = 1'b1;
    set_i        = 16'hFFFF;
    mask_i       = 16'h0000;
    done_ready_i = 1'b0;
    tick();
    tick();
    check("rst_flags", flags_o, 16'h0000);
    check("rst_done", done_valid_o, 1'b0);
    check("rst_pend", pend_o, 16'h0000);

    rst   = 1'b0;
    set_i = 16'h0000;
    tick();
    check("rel_flags", flags_o, 16'h0000);
    check("rel_done", done_valid_o, 1'b0);
    check("rel_round", round_o, 8'd0);
    check("rel_timeout", timeout_o, 1'b0);

    // Sequential join: one new lane per cycle.
    exp_flags = '0;
    for (int i = 0; i < WIDTH; i++) begin
      set_i     = 16'h0001 << i;
      exp_flags = exp_flags | (16'h0001 << i);
      tick();
      check($sformatf("seq_flags_%0d", i), flags_o, exp_flags);
      check($sformatf("seq_done_%0d", i), done_valid_o, (i == WIDTH - 1));
    end
    set_i = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_done_%0d", k), done_valid_o, 1'b1);
      check($sformatf("hold_flags_%0d", k), flags_o, 16'hFFFF);
    end
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    check("hs1_round", round_o, 8'd1);
    check("hs1_flags", flags_o, 16'h0000);
    check("hs1_done", done_valid_o, 1'b0);

    // Ready while collecting is ignored.
    done_ready_i = 1'b1;
    set_i        = 16'h0010;
    tick();
    done_ready_i = 1'b0;
    set_i        = 16'h0000;
    check("ign_round", round_o, 8'd1);
    check("ign_flags", flags_o, 16'h0010);
    // Re-pulse of a set lane is idempotent.
    set_i = 16'h0010;
    tick();
    set_i = 16'h0000;
    check("idem_flags", flags_o, 16'h0010);
    check("idem_done", done_valid_o, 1'b0);

    // Masking: upper lanes ignored.
    mask_i = 16'hFF00;
    set_i  = 16'h00EF;
    tick();
    set_i  = 16'h0000;
    check("mask_flags", flags_o, 16'h00FF);
    check("mask_done", done_valid_o, 1'b1);

    // Early next-round pulses are buffered in DONE.
    set_i = 16'h0003;
    tick();
    check("buf_pend", pend_o, 16'h0003);
    check("buf_flags", flags_o, 16'h00FF);
    check("buf_done", done_valid_o, 1'b1);
    set_i        = 16'h0004;
    done_ready_i = 1'b1;
    tick();
    set_i        = 16'h0000;
    done_ready_i = 1'b0;
    check("hs2_flags", flags_o, 16'h0007);
    check("hs2_pend", pend_o, 16'h0000);
    check("hs2_round", round_o, 8'd2);
    check("hs2_done", done_valid_o, 1'b0);

    // Round wrap with every lane masked and the consumer always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap_rst_round", round_o, 8'd0);
    check("wrap_rst_flags", flags_o, 16'h0000);
    mask_i       = 16'hFFFF;
    done_ready_i = 1'b1;
    exp_round    = '0;
    for (int r = 0; r < 256; r++) begin
      tick();
      check("wrap_done_hi", done_valid_o, 1'b1);
      exp_round = exp_round + 1'b1;
      tick();
      check("wrap_done_lo", done_valid_o, 1'b0);
      check("wrap_round", round_o, exp_round);
    end
    check("wrap_final", round_o, 8'd0);
    done_ready_i = 1'b0;
    mask_i       = 16'h0000;

    // Abort timer: one lane, then idle.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    set_i = 16'h0001;
    tick();
    set_i = 16'h0000;
    check("to_start_flags", flags_o, 16'h0001);
    for (int k = 1; k <= 9; k++) begin
      tick();
`ifdef FLAG_JOIN_TIMEOUT_EN
      check($sformatf("to_pulse_%0d", k), timeout_o, (k == 8));
      check($sformatf("to_flags_%0d", k), flags_o, (k >= 8) ? 16'h0000 : 16'h0001);
`else
      check($sformatf("to_pulse_%0d", k), timeout_o, 1'b0);
      check($sformatf("to_flags_%0d", k), flags_o, 16'h0001);
`endif
      check($sformatf("to_round_%0d", k), round_o, 8'd0);
    end

    // Reset mid-round clears everything.
    set_i = 16'h0300;
    tick();
    set_i = 16'h0000;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    check("mid_rst_flags", flags_o, 16'h0000);
    check("mid_rst_pend", pend_o, 16'h0000);
    check("mid_rst_done", done_valid_o, 1'b0);
    check("mid_rst_timeout", timeout_o, 1'b0);
    tick();
    check("mid_post_flags", flags_o, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
